// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - operation encodings, default latencies and counter sizing for mult_div_unit
package md_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;

  function automatic int md_cnt_width(input int mult_cycles, input int div_cycles);
    return $clog2(((mult_cycles > div_cycles) ? mult_cycles : div_cycles) + 1);
  endfunction

  localparam int MD_CNT_W = md_cnt_width(MD_MULT_CYCLES_DEF, MD_DIV_CYCLES_DEF);

endpackage

// File: rtl/md_arith.sv
// rtl/md_arith.sv - combinational 64-bit multiply/divide result {hi,lo} for mult_div_unit
module md_arith
  import md_pkg::*;
(
  input  logic [1:0]  mdop_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               a_neg, b_neg;
  logic [31:0]        dvd, dvs, dvs_safe, q_mag, r_mag, q_fin, r_fin;

  // Signed divide runs on magnitudes so INT_MIN / -1 wraps to INT_MIN cleanly.
  always_comb begin
    prod_s   = $signed({{32{a_i[31]}}, a_i}) * $signed({{32{b_i[31]}}, b_i});
    prod_u   = {32'd0, a_i} * {32'd0, b_i};
    a_neg    = (mdop_i == MD_DIV) && a_i[31];
    b_neg    = (mdop_i == MD_DIV) && b_i[31];
    dvd      = a_neg ? -a_i : a_i;
    dvs      = b_neg ? -b_i : b_i;
    dvs_safe = (dvs == 32'd0) ? 32'd1 : dvs;
    q_mag    = dvd / dvs_safe;
    r_mag    = dvd % dvs_safe;
    q_fin    = (a_neg ^ b_neg) ? -q_mag : q_mag;
    r_fin    = a_neg ? -r_mag : r_mag;
    res_o    = 64'd0;
    case (mdop_i)
      MD_MULT:  res_o = prod_s;
      MD_MULTU: res_o = prod_u;
      default: begin
        if (b_i == 32'd0) res_o = {a_i, 32'hFFFF_FFFF};
        else              res_o = {r_fin, q_fin};
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - multi-cycle mult/div unit holding HI/LO; MD_DIVZERO_HOLD_EN keeps HI/LO on divide by zero
module mult_div_unit
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  mdop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        wr_hi,
  input  logic        wr_lo,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [63:0]      res_q, res_d, arith_res;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
`ifdef MD_DIVZERO_HOLD_EN
  logic             dz_q, dz_d;
`endif

  md_arith u_arith (
    .mdop_i (mdop),
    .a_i    (a),
    .b_i    (b),
    .res_o  (arith_res)
  );

  always_comb begin
    cnt_d = cnt_q;
    res_d = res_q;
    hi_d  = hi_q;
    lo_d  = lo_q;
`ifdef MD_DIVZERO_HOLD_EN
    dz_d  = dz_q;
`endif
    if (cnt_q == '0) begin
      if (start) begin
        cnt_d = mdop[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        res_d = arith_res;
`ifdef MD_DIVZERO_HOLD_EN
        dz_d  = mdop[1] && (b == 32'd0);
`endif
      end else begin
        if (wr_hi) hi_d = a;
        if (wr_lo) lo_d = a;
      end
    end else begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CNT_W'(1)) begin
`ifdef MD_DIVZERO_HOLD_EN
        if (!dz_q) {hi_d, lo_d} = res_q;
`else
        {hi_d, lo_d} = res_q;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q <= '0;
      res_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
`ifdef MD_DIVZERO_HOLD_EN
      dz_q  <= 1'b0;
`endif
    end else begin
      cnt_q <= cnt_d;
      res_q <= res_d;
      hi_q  <= hi_d;
      lo_q  <= lo_d;
`ifdef MD_DIVZERO_HOLD_EN
      dz_q  <= dz_d;
`endif
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (clr && cnt_q != '0)
      assert (!(start || wr_hi || wr_lo))
        else $warning("mult_div_unit: request while busy ignored");
  end
`endif

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mdop = 2'b00;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        wr_hi = 1'b0;
  logic        wr_lo = 1'b0;
  logic        busy;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;

  mult_div_unit dut (
    .clk   (clk),
    .clr   (clr),
    .start (start),
    .mdop  (mdop),
    .a     (a),
    .b     (b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; leaves the bench at the first negedge where busy is low.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] av,
                       input logic [31:0] bv, input logic with_wr_lo, input int n_exp,
                       input logic [31:0] hi_exp, input logic [31:0] lo_exp);
    int n;
    start = 1'b1; mdop = op; a = av; b = bv; wr_lo = with_wr_lo;
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    check({tag, "_busy_rise"}, {31'd0, busy}, 32'd1);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, n, n_exp);
    check({tag, "_hi"}, hi, hi_exp);
    check({tag, "_lo"}, lo, lo_exp);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_hi", hi, 32'd0);
    check("reset_lo", lo, 32'd0);
    clr = 1'b1;
    @(negedge clk);

    do_op("mult",  2'b00, 32'hFFFF_FFFE, 32'd3, 1'b0, 5,  32'hFFFF_FFFF, 32'hFFFF_FFFA);
    do_op("multu", 2'b01, 32'hFFFF_FFFE, 32'd3, 1'b0, 5,  32'h0000_0002, 32'hFFFF_FFFA);
    do_op("div",   2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    do_op("divu",  2'b11, 32'd7,         32'd2, 1'b0, 10, 32'd1,         32'd3);
    do_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 10, 32'd0, 32'h8000_0000);

    wr_hi = 1'b1; wr_lo = 1'b1; a = 32'h1234;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    check("mthi_mtlo_hi", hi, 32'h1234);
    check("mthi_mtlo_lo", lo, 32'h1234);

`ifdef MD_DIVZERO_HOLD_EN
    do_op("divzero", 2'b10, 32'h55, 32'd0, 1'b0, 10, 32'h1234, 32'h1234);
`else
    do_op("divzero", 2'b10, 32'h55, 32'd0, 1'b0, 10, 32'h55, 32'hFFFF_FFFF);
`endif

    wr_hi = 1'b1; a = 32'hAA;
    @(negedge clk);
    wr_hi = 1'b0;
    check("mthi_hi", hi, 32'hAA);
`ifdef MD_DIVZERO_HOLD_EN
    check("mthi_lo_kept", lo, 32'h1234);
`else
    check("mthi_lo_kept", lo, 32'hFFFF_FFFF);
`endif

    do_op("start_wrlo", 2'b01, 32'd3, 32'd4, 1'b1, 5, 32'd0, 32'd12);

    start = 1'b1; mdop = 2'b00; a = 32'd2; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    wr_hi = 1'b1; a = 32'hDEAD;
    @(negedge clk);
    wr_hi = 1'b0;
    check("wrhi_busy_hi", hi, 32'd0);
    n = 0;
    while (busy && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("wrhi_busy_cycles", n, 4);
    check("wrhi_busy_hi_final", hi, 32'd0);
    check("wrhi_busy_lo_final", lo, 32'd10);

    do_op("b2b_mult", 2'b00, 32'd7, 32'd6, 1'b0, 5, 32'd0, 32'd42);

    start = 1'b1; mdop = 2'b10; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    repeat (2) @(negedge clk);
    clr = 1'b1;
    repeat (15) @(negedge clk);
    check("midrst_after_busy", {31'd0, busy}, 32'd0);
    check("midrst_after_hi", hi, 32'd0);
    check("midrst_after_lo", lo, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
